// File: rtl/ps2_keycode_rx_if.sv
// ps2_keycode_rx_if: PS/2 pin inputs and decoded key outputs of ps2_keycode_rx
//   ps2_clk, ps2_dat                 raw asynchronous PS/2 lines (driven by master)
//   keycode, press                   held make code and key-held level
//   rx_valid, rx_byte, frame_err     per-byte pulse, last byte, error pulse
interface ps2_keycode_rx_if;
  logic       ps2_clk;
  logic       ps2_dat;
  logic [7:0] keycode;
  logic       press;
  logic       rx_valid;
  logic [7:0] rx_byte;
  logic       frame_err;
  modport master (output ps2_clk, ps2_dat, input keycode, press, rx_valid, rx_byte, frame_err);
  modport slave  (input ps2_clk, ps2_dat, output keycode, press, rx_valid, rx_byte, frame_err);
endinterface

// File: rtl/ps2_keycode_rx.sv
// ps2_keycode_rx: PS/2 keyboard receiver with make/break/extended decode
//   clk_clk        system clock
//   reset_reset_n  asynchronous active-low reset, released synchronously
//   bus            ps2_keycode_rx_if.slave: ps2_clk/ps2_dat in; keycode, press,
//                  rx_valid, rx_byte, frame_err out
//   PS2_PARITY_CHECK_EN  when defined, a bad odd parity rejects the frame
module ps2_keycode_rx #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic           clk_clk,
  input  logic           reset_reset_n,
  ps2_keycode_rx_if.slave bus
);
  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, RECV, CHECK} state_t;
  logic [1:0]    rst_sync_q;
  logic          rst_n;
  logic [1:0]    sync1_q, sync2_q, filt_q, filt_d;
  logic [FW-1:0] fcnt_q [2];
  logic [FW-1:0] fcnt_d [2];
  logic          clk_prev_q, fall, dat;
  state_t        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [7:0]    sr_q, sr_d;
  logic          par_q, par_d, stop_q, stop_d, ok;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [7:0]    kc_q, kc_d, byte_q, byte_d;
  logic          press_q, press_d, vld_q, vld_d, err_q, err_d, brk_q, brk_d, ext_q, ext_d;
  // Reset asserts asynchronously but every other flop leaves reset on a clock edge.
  always_ff @(posedge clk_clk or negedge reset_reset_n)
    if (!reset_reset_n) rst_sync_q <= '0;
    else rst_sync_q <= {rst_sync_q[0], 1'b1};
  assign rst_n = rst_sync_q[1];
  // Index 0 is ps2_clk, index 1 is ps2_dat.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      filt_d[i] = filt_q[i];
      fcnt_d[i] = '0;
      if (sync2_q[i] != filt_q[i]) begin
        if (fcnt_q[i] == FW'(FILTER_LEN - 1)) filt_d[i] = sync2_q[i];
        else fcnt_d[i] = fcnt_q[i] + 1'b1;
      end
    end
  end
  assign fall = clk_prev_q & ~filt_q[0];
  assign dat  = filt_q[1];
`ifdef PS2_PARITY_CHECK_EN
  assign ok = stop_q & (^{sr_q, par_q});
`else
  assign ok = stop_q;
`endif
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sr_d    = sr_q;
    par_d   = par_q;
    stop_d  = stop_q;
    tmo_d   = tmo_q;
    kc_d    = kc_q;
    press_d = press_q;
    byte_d  = byte_q;
    brk_d   = brk_q;
    ext_d   = ext_q;
    vld_d   = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        tmo_d = '0;
        if (fall && !dat) begin
          state_d = RECV;
          cnt_d   = '0;
        end
      end
      RECV: begin
        if (fall) begin
          tmo_d = '0;
          cnt_d = cnt_q + 4'd1;
          if (cnt_q < 4'd8) sr_d = {dat, sr_q[7:1]};
          else if (cnt_q == 4'd8) par_d = dat;
          else begin
            stop_d  = dat;
            state_d = CHECK;
          end
        end else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
          state_d = IDLE;
          err_d   = 1'b1;
          tmo_d   = '0;
        end else tmo_d = tmo_q + 1'b1;
      end
      CHECK: begin
        state_d = IDLE;
        if (!ok) err_d = 1'b1;
        else begin
          vld_d  = 1'b1;
          byte_d = sr_q;
          if (sr_q == 8'hE0) ext_d = 1'b1;
          else if (sr_q == 8'hF0) brk_d = 1'b1;
          else if (brk_q) begin
            // Only the release of the tracked key drops press.
            if (sr_q == kc_q) press_d = 1'b0;
            brk_d = 1'b0;
            ext_d = 1'b0;
          end else begin
            kc_d    = sr_q;
            press_d = 1'b1;
            ext_d   = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_clk or negedge rst_n)
    if (!rst_n) begin
      sync1_q    <= 2'b11;
      sync2_q    <= 2'b11;
      filt_q     <= 2'b11;
      fcnt_q[0]  <= '0;
      fcnt_q[1]  <= '0;
      clk_prev_q <= 1'b1;
      state_q    <= IDLE;
      cnt_q      <= '0;
      sr_q       <= '0;
      par_q      <= 1'b0;
      stop_q     <= 1'b0;
      tmo_q      <= '0;
      kc_q       <= '0;
      press_q    <= 1'b0;
      byte_q     <= '0;
      vld_q      <= 1'b0;
      err_q      <= 1'b0;
      brk_q      <= 1'b0;
      ext_q      <= 1'b0;
    end else begin
      sync1_q    <= {bus.ps2_dat, bus.ps2_clk};
      sync2_q    <= sync1_q;
      filt_q     <= filt_d;
      fcnt_q[0]  <= fcnt_d[0];
      fcnt_q[1]  <= fcnt_d[1];
      clk_prev_q <= filt_q[0];
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sr_q       <= sr_d;
      par_q      <= par_d;
      stop_q     <= stop_d;
      tmo_q      <= tmo_d;
      kc_q       <= kc_d;
      press_q    <= press_d;
      byte_q     <= byte_d;
      vld_q      <= vld_d;
      err_q      <= err_d;
      brk_q      <= brk_d;
      ext_q      <= ext_d;
    end
  assign bus.keycode   = kc_q;
  assign bus.press     = press_q;
  assign bus.rx_valid  = vld_q;
  assign bus.rx_byte   = byte_q;
  assign bus.frame_err = err_q;
endmodule
